// File: rtl/game_pkg.sv
// Shared types and constants for the shot-count / ammo path.
package game_pkg;

    typedef enum logic [1:0] {
        READY     = 2'd0,
        EMPTY     = 2'd1,
        RELOADING = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    // Three-digit BCD count, hundreds in the top nibble so that the packed
    // value reads naturally as 12'hHTO.
    typedef struct packed {
        bcd_t hundreds;
        bcd_t tens;
        bcd_t ones;
    } count_t;

    localparam bcd_t BCD_NINE = 4'd9;
    localparam bcd_t BCD_ZERO = 4'd0;

endpackage

// File: rtl/button_edge_sync.sv
// Two-flop synchronizer for a raw asynchronous button followed by a
// rising-edge detector; a held button yields a single one-cycle pulse.
module button_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic rise
);

    logic sync_p0;
    logic sync_p1;
    logic dly_p2;

    // Synchronizer chain plus one delay flop for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            dly_p2  <= 1'b0;
        end else begin
            sync_p0 <= button;
            sync_p1 <= sync_p0;
            dly_p2  <= sync_p1;
        end
    end

    assign rise = sync_p1 & ~dly_p2;

endmodule

// File: rtl/ammo_down_counter.sv
// BCD remaining-shot counter: decrements on each accepted fire press,
// reports empty, and runs a timed reload back to the magazine size.
module ammo_down_counter
    import game_pkg::*;
#(
    parameter bcd_t START_HUNDREDS = 4'd0,
    parameter bcd_t START_TENS     = 4'd3,
    parameter bcd_t START_ONES     = 4'd0,
    parameter int   RELOAD_CYCLES  = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       error,
    input  logic       fire_in,
    input  logic       reload_in,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [3:0] hundreds,
    output logic       empty,
    output logic       reloading,
    output logic       shot,
    output logic       dry_fire
);

    localparam int TIMER_W = $clog2(RELOAD_CYCLES + 1);
    // Loading N-1 and leaving on the cycle the timer reads 0 keeps the
    // RELOADING state for exactly RELOAD_CYCLES cycles.
    localparam logic [TIMER_W-1:0] TIMER_LOAD  = TIMER_W'(RELOAD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ZERO  = '0;
    localparam count_t             START_COUNT = {START_HUNDREDS, START_TENS, START_ONES};
    localparam count_t             ONE_COUNT   = {BCD_ZERO, BCD_ZERO, 4'd1};
    localparam count_t             ZERO_COUNT  = {BCD_ZERO, BCD_ZERO, BCD_ZERO};

    // BCD decrement with borrow; callers never pass 000.
    function automatic count_t bcd_dec(input count_t c);
        count_t r;
        r = c;
        if (c.ones != BCD_ZERO) begin
            r.ones = c.ones - 4'd1;
        end else begin
            r.ones = BCD_NINE;
            if (c.tens != BCD_ZERO) begin
                r.tens = c.tens - 4'd1;
            end else begin
                r.tens     = BCD_NINE;
                r.hundreds = c.hundreds - 4'd1;
            end
        end
        return r;
    endfunction

    logic fire_rise;
    logic reload_rise;

    button_edge_sync u_fire_sync (
        .clk    (clk),
        .reset  (reset),
        .button (fire_in),
        .rise   (fire_rise)
    );

    button_edge_sync u_reload_sync (
        .clk    (clk),
        .reset  (reset),
        .button (reload_in),
        .rise   (reload_rise)
    );

    state_t             state;
    state_t             state_nxt;
    count_t             count;
    count_t             count_nxt;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_nxt;
    logic               shot_nxt;
    logic               dry_fire_nxt;

    logic fire_ok;
    logic reload_ok;

    assign fire_ok   = fire_rise & enable & ~error;
    assign reload_ok = reload_rise & enable;

    // State, count, timer and pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= READY;
            count    <= START_COUNT;
            timer    <= TIMER_ZERO;
            shot     <= 1'b0;
            dry_fire <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            timer    <= timer_nxt;
            shot     <= shot_nxt;
            dry_fire <= dry_fire_nxt;
        end
    end

    // Next-state, next-count and pulse decisions; reload outranks fire.
    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        timer_nxt    = timer;
        shot_nxt     = 1'b0;
        dry_fire_nxt = 1'b0;
        case (state)
            READY: begin
                if (reload_ok) begin
                    state_nxt = RELOADING;
                    timer_nxt = TIMER_LOAD;
                end else if (fire_ok && (count != ZERO_COUNT)) begin
                    shot_nxt  = 1'b1;
                    count_nxt = bcd_dec(count);
                    if (count == ONE_COUNT) begin
                        state_nxt = EMPTY;
                    end
                end
            end
            EMPTY: begin
                if (reload_ok) begin
                    state_nxt = RELOADING;
                    timer_nxt = TIMER_LOAD;
                end else if (fire_ok) begin
                    dry_fire_nxt = 1'b1;
                end
            end
            RELOADING: begin
                if (timer == TIMER_ZERO) begin
                    count_nxt = START_COUNT;
                    state_nxt = READY;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            default: begin
                state_nxt = READY;
            end
        endcase
    end

    assign ones      = count.ones;
    assign tens      = count.tens;
    assign hundreds  = count.hundreds;
    assign empty     = (state == EMPTY);
    assign reloading = (state == RELOADING);

endmodule

// File: tb/tb_ammo_down_counter.sv
// Directed bench: dut uses START=100, dut2 uses START=002, both RELOAD_CYCLES=4.
module tb_ammo_down_counter;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       error;
    logic       fire_in;
    logic       reload_in;

    logic [3:0] ones, tens, hundreds;
    logic       empty, reloading, shot, dry_fire;
    logic [3:0] ones2, tens2, hundreds2;
    logic       empty2, reloading2, shot2, dry_fire2;

    int checks = 0;
    int errors = 0;

    ammo_down_counter #(
        .START_HUNDREDS (4'd1),
        .START_TENS     (4'd0),
        .START_ONES     (4'd0),
        .RELOAD_CYCLES  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .error     (error),
        .fire_in   (fire_in),
        .reload_in (reload_in),
        .ones      (ones),
        .tens      (tens),
        .hundreds  (hundreds),
        .empty     (empty),
        .reloading (reloading),
        .shot      (shot),
        .dry_fire  (dry_fire)
    );

    ammo_down_counter #(
        .START_HUNDREDS (4'd0),
        .START_TENS     (4'd0),
        .START_ONES     (4'd2),
        .RELOAD_CYCLES  (4)
    ) dut2 (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .error     (error),
        .fire_in   (fire_in),
        .reload_in (reload_in),
        .ones      (ones2),
        .tens      (tens2),
        .hundreds  (hundreds2),
        .empty     (empty2),
        .reloading (reloading2),
        .shot      (shot2),
        .dry_fire  (dry_fire2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic shoot(input int n);
        for (int i = 0; i < n; i++) begin
            fire_in = 1'b1;
            repeat (3) tick();
            fire_in = 1'b0;
            repeat (3) tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; error = 1'b0; fire_in = 1'b0; reload_in = 1'b0;
        repeat (2) tick();
        checks++;
        if ({hundreds, tens, ones} !== 12'h100) begin
            errors++; $display("FAIL reset_digits got %h want 100", {hundreds, tens, ones});
        end
        checks++;
        if ({empty, reloading, shot, dry_fire} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b want 0000", {empty, reloading, shot, dry_fire});
        end
        checks++;
        if ({hundreds2, tens2, ones2} !== 12'h002) begin
            errors++; $display("FAIL reset_digits2 got %h want 002", {hundreds2, tens2, ones2});
        end
        reset = 1'b0;
    endtask

    task automatic test_single_press();
        int shots = 0;
        int first = -1;
        fire_in = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (shot === 1'b1) begin
                shots++;
                if (first < 0) first = i;
            end
        end
        fire_in = 1'b0;
        repeat (3) tick();
        checks++;
        if (shots !== 1) begin
            errors++; $display("FAIL held_press_shots got %0d want 1", shots);
        end
        checks++;
        if (first !== 3) begin
            errors++; $display("FAIL shot_latency got %0d want 3", first);
        end
        checks++;
        if ({hundreds, tens, ones} !== 12'h099) begin
            errors++; $display("FAIL double_borrow got %h want 099", {hundreds, tens, ones});
        end
    endtask

    task automatic test_empty();
        int dry = 0;
        int shots = 0;
        do_reset();
        fire_in = 1'b1; repeat (3) tick();
        checks++;
        if ({shot2, empty2, hundreds2, tens2, ones2} !== {2'b10, 12'h001}) begin
            errors++; $display("FAIL first_shot got shot=%b empty=%b %h want 1 0 001", shot2, empty2, {hundreds2, tens2, ones2});
        end
        fire_in = 1'b0; repeat (3) tick();
        fire_in = 1'b1; repeat (3) tick();
        checks++;
        if ({shot2, empty2, hundreds2, tens2, ones2} !== {2'b11, 12'h000}) begin
            errors++; $display("FAIL last_shot got shot=%b empty=%b %h want 1 1 000", shot2, empty2, {hundreds2, tens2, ones2});
        end
        fire_in = 1'b0; repeat (3) tick();
        fire_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) fire_in = 1'b0;
            tick();
            if (dry_fire2 === 1'b1) dry++;
            if (shot2 === 1'b1) shots++;
        end
        checks++;
        if (dry !== 1 || shots !== 0) begin
            errors++; $display("FAIL dry_fire got dry=%0d shots=%0d want 1 0", dry, shots);
        end
        checks++;
        if ({empty2, hundreds2, tens2, ones2} !== {1'b1, 12'h000}) begin
            errors++; $display("FAIL empty_hold got empty=%b %h want 1 000", empty2, {hundreds2, tens2, ones2});
        end
    endtask

    task automatic test_reload_ignores_fire();
        int hi = 1;
        int sd = 0;
        reload_in = 1'b1; repeat (3) tick();
        checks++;
        if (reloading2 !== 1'b1) begin
            errors++; $display("FAIL reload_enter got %b want 1", reloading2);
        end
        reload_in = 1'b0;
        fire_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (reloading2 === 1'b1) hi++;
            if (shot2 === 1'b1 || dry_fire2 === 1'b1 || shot === 1'b1) sd++;
        end
        fire_in = 1'b0; repeat (3) tick();
        checks++;
        if (hi !== 4) begin
            errors++; $display("FAIL reload_length got %0d want 4", hi);
        end
        checks++;
        if (sd !== 0) begin
            errors++; $display("FAIL reload_fire_ignored got %0d pulses want 0", sd);
        end
        checks++;
        if ({empty2, reloading2, hundreds2, tens2, ones2} !== {2'b00, 12'h002}) begin
            errors++; $display("FAIL reload_done2 got e=%b r=%b %h want 0 0 002", empty2, reloading2, {hundreds2, tens2, ones2});
        end
        checks++;
        if ({hundreds, tens, ones} !== 12'h100) begin
            errors++; $display("FAIL reload_done got %h want 100", {hundreds, tens, ones});
        end
    endtask

    task automatic test_same_cycle();
        int shots = 0;
        shoot(43);
        checks++;
        if ({hundreds, tens, ones} !== 12'h057) begin
            errors++; $display("FAIL count_57 got %h want 057", {hundreds, tens, ones});
        end
        fire_in = 1'b1; reload_in = 1'b1;
        repeat (3) tick();
        checks++;
        if ({reloading, shot, hundreds, tens, ones} !== {2'b10, 12'h057}) begin
            errors++; $display("FAIL reload_priority got r=%b s=%b %h want 1 0 057", reloading, shot, {hundreds, tens, ones});
        end
        fire_in = 1'b0; reload_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (shot === 1'b1) shots++;
        end
        checks++;
        if ({shots[0], reloading, hundreds, tens, ones} !== {2'b00, 12'h100} || shots !== 0) begin
            errors++; $display("FAIL after_priority got shots=%0d r=%b %h want 0 0 100", shots, reloading, {hundreds, tens, ones});
        end
    endtask

    task automatic test_error_enable();
        int shots = 0;
        shoot(58);
        checks++;
        if ({hundreds, tens, ones} !== 12'h042) begin
            errors++; $display("FAIL count_42 got %h want 042", {hundreds, tens, ones});
        end
        error = 1'b1;
        shoot(1);
        checks++;
        if ({hundreds, tens, ones} !== 12'h042) begin
            errors++; $display("FAIL error_blocks got %h want 042", {hundreds, tens, ones});
        end
        error = 1'b0; enable = 1'b0;
        fire_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) fire_in = 1'b0;
            tick();
            if (shot === 1'b1) shots++;
        end
        checks++;
        if (shots !== 0 || {hundreds, tens, ones} !== 12'h042) begin
            errors++; $display("FAIL enable_blocks got shots=%0d %h want 0 042", shots, {hundreds, tens, ones});
        end
        enable = 1'b1; error = 1'b1;
        reload_in = 1'b1; repeat (3) tick();
        checks++;
        if ({reloading, hundreds, tens, ones} !== {1'b1, 12'h042}) begin
            errors++; $display("FAIL error_reload got r=%b %h want 1 042", reloading, {hundreds, tens, ones});
        end
        reload_in = 1'b0;
        tick();
        checks++;
        if (reloading !== 1'b1) begin
            errors++; $display("FAIL reload_cycle2 got %b want 1", reloading);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({reloading, empty, hundreds, tens, ones} !== {2'b00, 12'h100}) begin
            errors++; $display("FAIL reset_abort got r=%b e=%b %h want 0 0 100", reloading, empty, {hundreds, tens, ones});
        end
        reset = 1'b0; error = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; error = 1'b0; fire_in = 1'b0; reload_in = 1'b0;
        test_reset();
        test_single_press();
        test_empty();
        test_reload_ignores_fire();
        test_same_cycle();
        test_error_enable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
